wdb_entry_alloc: RTL



---
 rtl/wdb_entry_alloc.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/wdb_entry_alloc.sv
// ----------------------------------------------------------------------------
// wdb_entry_alloc
//
// Per-lane write-data-buffer entry allocator. Each lane owns a private pool of
// ENTRY_NUM entries tracked by a free bitmap. A one-entry registered slot
// pre-fetches the lowest free entry, so the crossbar always sees a ready index
// when one exists. Entries return to the pool when the downstream WDB drains
// them.
//
// Ports
//   clk_i                clock
//   rst_i                synchronous active-high reset
//   alloc_vld_o[i]       lane i slot holds a free entry
//   alloc_idx_o[i]       global entry index {lane, local}
//   alloc_rdy_i[i]       consumer takes the lane i entry this cycle
//   rel_vld_i[i]         release request on lane i
//   rel_idx_i[i]         global index being released on lane i
//   free_cnt_o[i]        free entries on lane i, slot included
//   err_double_free_o    sticky: release of an entry that was already free
//   err_lane_mismatch_o  sticky: release whose lane field names another lane
// ----------------------------------------------------------------------------
module wdb_entry_alloc #(
    parameter int LANE_NUM  = 4,
    parameter int ENTRY_NUM = 16,
    parameter int IDX_W     = $clog2(LANE_NUM) + $clog2(ENTRY_NUM),
    localparam int CNT_W    = $clog2(ENTRY_NUM + 1)
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    output logic [LANE_NUM-1:0]            alloc_vld_o,
    output logic [LANE_NUM-1:0][IDX_W-1:0] alloc_idx_o,
    input  logic [LANE_NUM-1:0]            alloc_rdy_i,
    input  logic [LANE_NUM-1:0]            rel_vld_i,
    input  logic [LANE_NUM-1:0][IDX_W-1:0] rel_idx_i,
    output logic [LANE_NUM-1:0][CNT_W-1:0] free_cnt_o,
    output logic [LANE_NUM-1:0]            err_double_free_o,
    output logic [LANE_NUM-1:0]            err_lane_mismatch_o
);

    localparam int LANE_W = $clog2(LANE_NUM);
    localparam int LOC_W  = $clog2(ENTRY_NUM);

    if (IDX_W != LANE_W + LOC_W) begin : g_bad_idx_w
        $error("wdb_entry_alloc: IDX_W must equal $clog2(LANE_NUM)+$clog2(ENTRY_NUM)");
    end
    if (ENTRY_NUM < 2 || (ENTRY_NUM & (ENTRY_NUM - 1)) != 0) begin : g_bad_entry_num
        $error("wdb_entry_alloc: ENTRY_NUM must be a power of two and at least 2");
    end
    if (LANE_NUM < 2) begin : g_bad_lane_num
        $error("wdb_entry_alloc: LANE_NUM must be at least 2");
    end

    for (genvar i = 0; i < LANE_NUM; i++) begin : g_lane
        logic [ENTRY_NUM-1:0] free_map_q, free_map_d;
        logic                 slot_vld_q, slot_vld_d;
        logic [IDX_W-1:0]     idx_q, idx_d;
        logic [CNT_W-1:0]     cnt_q, cnt_d;
        logic                 err_df_q, err_df_d;
        logic                 err_lm_q, err_lm_d;

        logic                 hs;
        logic                 refill;
        logic                 pick_vld;
        logic [LOC_W-1:0]     pick_loc;
        logic [LOC_W-1:0]     slot_loc;
        logic [LANE_W-1:0]    rel_lane;
        logic [LOC_W-1:0]     rel_loc;
        logic                 lane_bad;
        logic                 dbl_free;
        logic                 rel_ok;

        // The slot's local index lives in the low bits of the output register;
        // the lane field is zero only until the first refill after reset.
        assign slot_loc = idx_q[LOC_W-1:0];
        assign hs       = slot_vld_q & alloc_rdy_i[i];
        assign refill   = ~slot_vld_q | hs;

        assign rel_lane = rel_idx_i[i][IDX_W-1 -: LANE_W];
        assign rel_loc  = rel_idx_i[i][LOC_W-1:0];
        assign lane_bad = rel_vld_i[i] && (rel_lane != LANE_W'(i));
        // An entry parked in the slot is still owned by the allocator, so
        // releasing it counts as a double free.
        assign dbl_free = rel_vld_i[i] && !lane_bad &&
                          (free_map_q[rel_loc] || (slot_vld_q && (slot_loc == rel_loc)));
        assign rel_ok   = rel_vld_i[i] && !lane_bad && !dbl_free;

        // Lowest set bit of the pre-release bitmap; scanning downward lets the
        // last hit win.
        always_comb begin
            pick_vld = 1'b0;
            pick_loc = '0;
            for (int e = ENTRY_NUM - 1; e >= 0; e--) begin
                if (free_map_q[e]) begin
                    pick_vld = 1'b1;
                    pick_loc = LOC_W'(e);
                end
            end
        end

        // A released entry can never collide with the picked one: the pick is
        // a set bit, an accepted release targets a clear bit.
        always_comb begin
            free_map_d = free_map_q;
            slot_vld_d = slot_vld_q;
            idx_d      = idx_q;
            if (refill) begin
                slot_vld_d = pick_vld;
                if (pick_vld) begin
                    free_map_d[pick_loc] = 1'b0;
                    idx_d                = {LANE_W'(i), pick_loc};
                end
            end
            if (rel_ok) begin
                free_map_d[rel_loc] = 1'b1;
            end
            cnt_d    = cnt_q - CNT_W'(hs) + CNT_W'(rel_ok);
            err_df_d = err_df_q | dbl_free;
            err_lm_d = err_lm_q | lane_bad;
        end

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                free_map_q <= '1;
                slot_vld_q <= 1'b0;
                idx_q      <= '0;
                cnt_q      <= CNT_W'(ENTRY_NUM);
                err_df_q   <= 1'b0;
                err_lm_q   <= 1'b0;
            end else begin
                free_map_q <= free_map_d;
                slot_vld_q <= slot_vld_d;
                idx_q      <= idx_d;
                cnt_q      <= cnt_d;
                err_df_q   <= err_df_d;
                err_lm_q   <= err_lm_d;
            end
        end

        assign alloc_vld_o[i]         = slot_vld_q;
        assign alloc_idx_o[i]         = idx_q;
        assign free_cnt_o[i]          = cnt_q;
        assign err_double_free_o[i]   = err_df_q;
        assign err_lane_mismatch_o[i] = err_lm_q;
    end

endmodule
